gb_cpu_regfile: RTL and testbench

GB_CPU_REGFILE -- requirements
Module: gb_cpu_regfile

---
 rtl/gb_cpu_common_pkg.sv | 33 +++
 rtl/gb_cpu_regfile.sv | 144 ++++++++++++++
 tb/tb_gb_cpu_regfile.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_common_pkg.sv
// -----------------------------------------------------------------------------
// gb_cpu_common_pkg
// Shared definitions for the Game Boy CPU datapath: register selector
// encodings for the 8-bit file and the 16-bit pairs, and the architectural
// reset values of SP and PC.
// -----------------------------------------------------------------------------
package gb_cpu_common_pkg;

    // 8-bit register selector. Pairs are laid out so that a pair index p
    // maps to high byte 2p and low byte 2p+1 (B/C, D/E, H/L).
    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_F = 3'd6,
        REG_A = 3'd7
    } reg8_t;

    // 16-bit pair selector.
    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_SP = 2'd3
    } reg16_pair_t;

    localparam logic [15:0] SP_RESET = 16'hFFFE;
    localparam logic [15:0] PC_RESET = 16'h0000;

endpackage : gb_cpu_common_pkg

// File: rtl/gb_cpu_regfile.sv
// -----------------------------------------------------------------------------
// gb_cpu_regfile
// Register file for the Game Boy CPU: A,F,B,C,D,E,H,L, SP and PC.
//
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   RD_SEL_0/1, RD_DATA_0/1     two combinational 8-bit read ports (ALU inputs)
//   CARRY_OUT                   stored carry flag F[4]
//   WR_EN, WR_SEL, WR_DATA      8-bit write port (ALU result)
//   FLAG_WE, FLAG_IN            per-flag write mask/values, ordered {Z,N,H,C}
//   PAIR_SEL, PAIR_RD           16-bit pair select (BC,DE,HL,SP) and read
//   PAIR_WE, PAIR_WR_DATA       16-bit pair load
//   PAIR_INC, PAIR_DEC          modulo-2^16 pair increment / decrement
//   PC_OUT, PC_INC, PC_LOAD,
//   PC_LOAD_DATA                program counter and its update controls
//   DBG_REGS                    (only with GB_CPU_REGFILE_DBG_EN defined)
//                               {A,F,B,C,D,E,H,L,SP,PC}, MSB first
//
// Configuration macro: GB_CPU_REGFILE_DBG_EN
// -----------------------------------------------------------------------------
module gb_cpu_regfile
    import gb_cpu_common_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  RD_SEL_0,
    input  logic [2:0]  RD_SEL_1,
    output logic [7:0]  RD_DATA_0,
    output logic [7:0]  RD_DATA_1,
    output logic        CARRY_OUT,
    input  logic        WR_EN,
    input  logic [2:0]  WR_SEL,
    input  logic [7:0]  WR_DATA,
    input  logic [3:0]  FLAG_WE,
    input  logic [3:0]  FLAG_IN,
    input  logic [1:0]  PAIR_SEL,
    output logic [15:0] PAIR_RD,
    input  logic        PAIR_WE,
    input  logic [15:0] PAIR_WR_DATA,
    input  logic        PAIR_INC,
    input  logic        PAIR_DEC,
    output logic [15:0] PC_OUT,
    input  logic        PC_INC,
    input  logic        PC_LOAD,
    input  logic [15:0] PC_LOAD_DATA
`ifdef GB_CPU_REGFILE_DBG_EN
    ,
    output logic [95:0] DBG_REGS
`endif
);

    // Slot REG_F of the byte array is never written; F lives in f_hi, whose
    // bits 3..0 are Z,N,H,C (F[7:4]). F[3:0] therefore cannot hold anything.
    logic [7:0]  r8     [0:7];
    logic [3:0]  f_hi;
    logic [15:0] sp;
    logic [15:0] pc;

    logic [7:0]  r8_nxt [0:7];
    logic [3:0]  f_nxt;
    logic [15:0] sp_nxt;
    logic [15:0] pc_nxt;

    logic [2:0]  hi_idx;
    logic [2:0]  lo_idx;
    logic [15:0] pair_cur;
    logic [15:0] pair_new;
    logic        pair_upd;

    // ---------------------------------------------------------------- reads
    assign RD_DATA_0 = (RD_SEL_0 == REG_F) ? {f_hi, 4'h0} : r8[RD_SEL_0];
    assign RD_DATA_1 = (RD_SEL_1 == REG_F) ? {f_hi, 4'h0} : r8[RD_SEL_1];
    assign CARRY_OUT = f_hi[0];
    assign PC_OUT    = pc;

    assign hi_idx   = {PAIR_SEL, 1'b0};
    assign lo_idx   = {PAIR_SEL, 1'b1};
    assign pair_cur = (PAIR_SEL == PAIR_SP) ? sp : {r8[hi_idx], r8[lo_idx]};
    assign PAIR_RD  = pair_cur;

`ifdef GB_CPU_REGFILE_DBG_EN
    assign DBG_REGS = {r8[REG_A], f_hi, 4'h0, r8[REG_B], r8[REG_C], r8[REG_D],
                       r8[REG_E], r8[REG_H], r8[REG_L], sp, pc};
`endif

    // ----------------------------------------------------------- next state
    // INC and DEC together cancel; a pair load overrides both.
    assign pair_upd = PAIR_WE | (PAIR_INC ^ PAIR_DEC);
    assign pair_new = PAIR_WE  ? PAIR_WR_DATA :
                      PAIR_INC ? pair_cur + 16'd1 :
                                 pair_cur - 16'd1;

    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        r8_nxt = r8;
        f_nxt  = f_hi;
        sp_nxt = sp;
        pc_nxt = pc;

        if (WR_EN) begin
            if (WR_SEL == REG_F) f_nxt = WR_DATA[7:4];
            else                 r8_nxt[WR_SEL] = WR_DATA;
        end

        // Masked flags override an 8-bit write to F in the same cycle.
        for (int i = 0; i < 4; i++) begin
            if (FLAG_WE[i]) f_nxt[i] = FLAG_IN[i];
        end

        // Applied after the 8-bit write so the pair operation owns its bytes.
        if (pair_upd) begin
            if (PAIR_SEL == PAIR_SP) begin
                sp_nxt = pair_new;
            end else begin
                r8_nxt[hi_idx] = pair_new[15:8];
                r8_nxt[lo_idx] = pair_new[7:0];
            end
        end

        if (PC_LOAD)     pc_nxt = PC_LOAD_DATA;
        else if (PC_INC) pc_nxt = pc + 16'd1;
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the byte array is reset explicitly; it is a handful of
            // architectural flops, not a RAM, so reset costs nothing.
            for (int i = 0; i < 8; i++) r8[i] <= 8'h00;
            f_hi <= 4'h0;
            sp   <= SP_RESET;
            pc   <= PC_RESET;
        end else begin
            r8   <= r8_nxt;
            f_hi <= f_nxt;
            sp   <= sp_nxt;
            pc   <= pc_nxt;
        end
    end

endmodule : gb_cpu_regfile

// File: tb/tb_gb_cpu_regfile.sv
// -----------------------------------------------------------------------------
// tb_gb_cpu_regfile
// Directed scenarios plus randomized traffic against a behavioural model of
// the register file (bytes B..A in an int array, F kept as a full byte, SP/PC
// as integers with explicit modulo arithmetic).
// -----------------------------------------------------------------------------
module tb_gb_cpu_regfile;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  RD_SEL_0, RD_SEL_1;
    logic [7:0]  RD_DATA_0, RD_DATA_1;
    logic        CARRY_OUT;
    logic        WR_EN;
    logic [2:0]  WR_SEL;
    logic [7:0]  WR_DATA;
    logic [3:0]  FLAG_WE, FLAG_IN;
    logic [1:0]  PAIR_SEL;
    logic [15:0] PAIR_RD;
    logic        PAIR_WE;
    logic [15:0] PAIR_WR_DATA;
    logic        PAIR_INC, PAIR_DEC;
    logic [15:0] PC_OUT;
    logic        PC_INC, PC_LOAD;
    logic [15:0] PC_LOAD_DATA;
`ifdef GB_CPU_REGFILE_DBG_EN
    logic [95:0] DBG_REGS;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: index = selector code (B,C,D,E,H,L,F,A).
    int m8 [8];
    int msp;
    int mpc;

    gb_cpu_regfile dut (
        .CLK(CLK), .RESET(RESET),
        .RD_SEL_0(RD_SEL_0), .RD_SEL_1(RD_SEL_1),
        .RD_DATA_0(RD_DATA_0), .RD_DATA_1(RD_DATA_1),
        .CARRY_OUT(CARRY_OUT),
        .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
        .FLAG_WE(FLAG_WE), .FLAG_IN(FLAG_IN),
        .PAIR_SEL(PAIR_SEL), .PAIR_RD(PAIR_RD), .PAIR_WE(PAIR_WE),
        .PAIR_WR_DATA(PAIR_WR_DATA), .PAIR_INC(PAIR_INC), .PAIR_DEC(PAIR_DEC),
        .PC_OUT(PC_OUT), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
        .PC_LOAD_DATA(PC_LOAD_DATA)
`ifdef GB_CPU_REGFILE_DBG_EN
        , .DBG_REGS(DBG_REGS)
`endif
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------- model
    function automatic int pair_val(input int p);
        if (p == 3) return msp;
        return m8[2*p] * 256 + m8[2*p+1];
    endfunction

    task automatic model_step();
        int n8 [8];
        int pv, np;
        bit has_pair;
        if (RESET) begin
            for (int i = 0; i < 8; i++) m8[i] = 0;
            msp = 16'hFFFE;
            mpc = 0;
            return;
        end
        n8 = m8;
        if (WR_EN) n8[WR_SEL] = (WR_SEL == 3'd6) ? (int'(WR_DATA) & 8'hF0) : int'(WR_DATA);
        for (int i = 0; i < 4; i++)
            if (FLAG_WE[i]) n8[6] = FLAG_IN[i] ? (n8[6] | (16 << i)) : (n8[6] & ~(16 << i));
        pv = pair_val(int'(PAIR_SEL));
        has_pair = 1'b1;
        if (PAIR_WE)                 np = int'(PAIR_WR_DATA);
        else if (PAIR_INC && !PAIR_DEC) np = (pv + 1) % 65536;
        else if (PAIR_DEC && !PAIR_INC) np = (pv + 65535) % 65536;
        else begin np = pv; has_pair = 1'b0; end
        if (has_pair) begin
            if (PAIR_SEL == 2'd3) msp = np;
            else begin
                n8[2*PAIR_SEL]   = np / 256;
                n8[2*PAIR_SEL+1] = np % 256;
            end
        end
        m8 = n8;
        if (PC_LOAD)     mpc = int'(PC_LOAD_DATA);
        else if (PC_INC) mpc = (mpc + 1) % 65536;
    endtask

    // ---------------------------------------------------------- stimulus
    task automatic idle();
        RESET = 0; WR_EN = 0; WR_SEL = 0; WR_DATA = 0;
        FLAG_WE = 0; FLAG_IN = 0; PAIR_WE = 0; PAIR_WR_DATA = 0;
        PAIR_INC = 0; PAIR_DEC = 0; PC_INC = 0; PC_LOAD = 0; PC_LOAD_DATA = 0;
    endtask

    // One clock edge; model advances with the inputs present at the edge.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        // Reset with every write port active: all of it must be discarded.
        RESET = 1; WR_EN = 1; WR_SEL = 3'd7; WR_DATA = 8'h99;
        FLAG_WE = 4'hF; FLAG_IN = 4'hF; PAIR_SEL = 2'd3; PAIR_WE = 1;
        PAIR_WR_DATA = 16'h1111; PC_LOAD = 1; PC_LOAD_DATA = 16'h2222;
        cycle();
        idle();
        PAIR_SEL = 2'd3;
        #1;
        checks++;
        if (PC_OUT !== 16'h0000) begin
            failures++; $display("FAIL reset_pc got=%h exp=0000", PC_OUT);
        end
        checks++;
        if (PAIR_RD !== 16'hFFFE) begin
            failures++; $display("FAIL reset_sp got=%h exp=FFFE", PAIR_RD);
        end
        checks++;
        if (CARRY_OUT !== 1'b0) begin
            failures++; $display("FAIL reset_carry got=%b exp=0", CARRY_OUT);
        end
        for (int s = 0; s < 8; s++) begin
            RD_SEL_0 = 3'(s); RD_SEL_1 = 3'(7 - s);
            #1;
            checks++;
            if (RD_DATA_0 !== 8'h00 || RD_DATA_1 !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg sel=%0d got=%h/%h exp=00/00", s, RD_DATA_0, RD_DATA_1);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        WR_EN = 1; WR_SEL = 3'd7; WR_DATA = 8'h3C; RD_SEL_0 = 3'd7;
        #1;
        checks++;
        if (RD_DATA_0 !== 8'h00) begin
            failures++; $display("FAIL wr_no_bypass got=%h exp=00", RD_DATA_0);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (RD_DATA_0 !== 8'h3C) begin
            failures++; $display("FAIL wr_visible got=%h exp=3C", RD_DATA_0);
        end
    endtask

    task automatic test_flags();
        idle();
        WR_EN = 1; WR_SEL = 3'd6; WR_DATA = 8'hFF; FLAG_WE = 4'b0101; FLAG_IN = 4'b0000;
        cycle();
        idle(); RD_SEL_0 = 3'd6;
        #1;
        checks++;
        if (RD_DATA_0 !== 8'hA0 || CARRY_OUT !== 1'b0) begin
            failures++; $display("FAIL flag_merge got=%h c=%b exp=A0 c=0", RD_DATA_0, CARRY_OUT);
        end
        FLAG_WE = 4'b0001; FLAG_IN = 4'b1111;
        cycle();
        idle();
        #1;
        checks++;
        if (RD_DATA_0 !== 8'hB0 || CARRY_OUT !== 1'b1) begin
            failures++; $display("FAIL flag_carry got=%h c=%b exp=B0 c=1", RD_DATA_0, CARRY_OUT);
        end
        WR_EN = 1; WR_SEL = 3'd6; WR_DATA = 8'h0F;
        cycle();
        idle();
        #1;
        checks++;
        if (RD_DATA_0 !== 8'h00) begin
            failures++; $display("FAIL flag_low_nibble got=%h exp=00", RD_DATA_0);
        end
    endtask

    task automatic test_pair_wrap();
        logic [15:0] exp_seq [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0100};
        idle();
        PAIR_SEL = 2'd2; PAIR_WE = 1; PAIR_WR_DATA = 16'hFFFF;
        cycle();
        for (int k = 0; k < 4; k++) begin
            idle();
            PAIR_SEL = 2'd2;
            case (k)
                0: PAIR_INC = 1;
                1: PAIR_DEC = 1;
                2: begin PAIR_INC = 1; PAIR_DEC = 1; end
                default: ;
            endcase
            if (k == 3) begin
                // Byte carry on DE: 00FF + 1 = 0100.
                PAIR_SEL = 2'd1; PAIR_WE = 1; PAIR_WR_DATA = 16'h00FF;
                cycle();
                idle(); PAIR_SEL = 2'd1; PAIR_INC = 1;
            end
            cycle();
            idle();
            PAIR_SEL = (k == 3) ? 2'd1 : 2'd2;
            RD_SEL_1 = 3'd6;
            #1;
            checks++;
            if (PAIR_RD !== exp_seq[k]) begin
                failures++; $display("FAIL pair_wrap step=%0d got=%h exp=%h", k, PAIR_RD, exp_seq[k]);
            end
        end
        // Pair traffic must leave F exactly as the earlier flag test left it.
        checks++;
        if (RD_DATA_1 !== 8'h00) begin
            failures++; $display("FAIL pair_no_flags got=%h exp=00", RD_DATA_1);
        end
    endtask

    task automatic test_pair_collision();
        idle();
        PAIR_SEL = 2'd2; PAIR_WE = 1; PAIR_WR_DATA = 16'h1234;
        cycle();
        PAIR_WR_DATA = 16'hABCD; WR_EN = 1; WR_SEL = 3'd5; WR_DATA = 8'h55;
        cycle();
        idle(); PAIR_SEL = 2'd2;
        #1;
        checks++;
        if (PAIR_RD !== 16'hABCD) begin
            failures++; $display("FAIL pair_vs_byte got=%h exp=ABCD", PAIR_RD);
        end
        // Increment HL while writing B: both land.
        PAIR_INC = 1; WR_EN = 1; WR_SEL = 3'd0; WR_DATA = 8'h77;
        cycle();
        idle(); PAIR_SEL = 2'd2; RD_SEL_0 = 3'd0;
        #1;
        checks++;
        if (PAIR_RD !== 16'hABCE || RD_DATA_0 !== 8'h77) begin
            failures++; $display("FAIL pair_other_byte got=%h/%h exp=ABCE/77", PAIR_RD, RD_DATA_0);
        end
    endtask

    task automatic test_pc();
        logic [15:0] exp_pc [3] = '{16'h0000, 16'h0100, 16'h0101};
        idle();
        PC_LOAD = 1; PC_LOAD_DATA = 16'hFFFF;
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle();
            PC_INC = 1;
            if (k == 1) begin PC_LOAD = 1; PC_LOAD_DATA = 16'h0100; end
            cycle();
            idle();
            #1;
            checks++;
            if (PC_OUT !== exp_pc[k]) begin
                failures++; $display("FAIL pc step=%0d got=%h exp=%h", k, PC_OUT, exp_pc[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            RESET        = ($urandom_range(0, 39) == 0);
            WR_EN        = 1'($urandom);
            WR_SEL       = 3'($urandom);
            WR_DATA      = 8'($urandom);
            FLAG_WE      = 4'($urandom);
            FLAG_IN      = 4'($urandom);
            PAIR_SEL     = 2'($urandom);
            PAIR_WE      = ($urandom_range(0, 3) == 0);
            PAIR_WR_DATA = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            PAIR_INC     = 1'($urandom);
            PAIR_DEC     = 1'($urandom);
            PC_INC       = 1'($urandom);
            PC_LOAD      = ($urandom_range(0, 7) == 0);
            PC_LOAD_DATA = 16'($urandom_range(65500, 65535));
            RD_SEL_0     = 3'($urandom);
            RD_SEL_1     = 3'($urandom);
            #1;
            checks++;
            if (int'(RD_DATA_0) !== m8[RD_SEL_0] || int'(RD_DATA_1) !== m8[RD_SEL_1]) begin
                failures++;
                $display("FAIL rand_rd n=%0d sel=%0d/%0d got=%h/%h exp=%h/%h", n, RD_SEL_0,
                         RD_SEL_1, RD_DATA_0, RD_DATA_1, m8[RD_SEL_0], m8[RD_SEL_1]);
            end
            checks++;
            if (int'(PAIR_RD) !== pair_val(int'(PAIR_SEL)) || int'(PC_OUT) !== mpc ||
                CARRY_OUT !== 1'((m8[6] >> 4) & 1)) begin
                failures++;
                $display("FAIL rand_state n=%0d pair=%h pc=%h c=%b exp pair=%h pc=%h f=%h", n,
                         PAIR_RD, PC_OUT, CARRY_OUT, pair_val(int'(PAIR_SEL)), mpc, m8[6]);
            end
`ifdef GB_CPU_REGFILE_DBG_EN
            checks++;
            if (DBG_REGS !== {8'(m8[7]), 8'(m8[6]), 8'(m8[0]), 8'(m8[1]), 8'(m8[2]),
                              8'(m8[3]), 8'(m8[4]), 8'(m8[5]), 16'(msp), 16'(mpc)}) begin
                failures++; $display("FAIL rand_dbg n=%0d got=%h", n, DBG_REGS);
            end
`endif
            cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        RD_SEL_0 = 0; RD_SEL_1 = 0; PAIR_SEL = 0;
        @(negedge CLK);
        test_reset();
        test_write_read();
        test_flags();
        test_pair_wrap();
        test_pair_collision();
        test_pc();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gb_cpu_regfile
